// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war referee.
package tug_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    WIN       = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_RIGHT = 2'b01,
    WIN_LEFT  = 2'b10
  } winner_t;

  // Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: one-cycle pulse when a synchronized level first goes high.
// Combinational output from the live level, so the pulse acts on the same edge.
module edge_pulse (
  input  logic clk,
  input  logic Reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/tug_referee.sv
// Tug-of-war game controller: pull detection, lamp position, round scoring, win/game-over sequencing.
// Optional macro TUG_CPU_EN replaces the right player with an LFSR-driven CPU (adds cpu_level port).
module tug_referee
  import tug_pkg::*;
#(
  parameter int NUM_LIGHTS  = 9,
  parameter int SCORE_W     = 3,
  parameter int WIN_SCORE   = 3,
  parameter int HOLD_CYCLES = 4
`ifdef TUG_CPU_EN
  , parameter int CPU_PERIOD = 8
`endif
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  L,
  input  logic                  R,
  input  logic                  new_game,
`ifdef TUG_CPU_EN
  input  logic [3:0]            cpu_level,
`endif
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [1:0]            winner,
  output logic [SCORE_W-1:0]    score_l,
  output logic [SCORE_W-1:0]    score_r,
  output logic                  game_over
);

  localparam int POS_W  = $clog2(NUM_LIGHTS);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [POS_W-1:0]   POS_CENTER = POS_W'((NUM_LIGHTS - 1) / 2);
  localparam logic [POS_W-1:0]   POS_TOP    = POS_W'(NUM_LIGHTS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);

  state_t               state_q, state_d;
  winner_t              winner_q, winner_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [SCORE_W-1:0]   score_l_q, score_l_d;
  logic [SCORE_W-1:0]   score_r_q, score_r_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 lp, rp;

  edge_pulse u_left (
    .clk   (clk),
    .Reset (Reset),
    .level (L),
    .pulse (lp)
  );

`ifdef TUG_CPU_EN
  localparam int PER_W = (CPU_PERIOD > 1) ? $clog2(CPU_PERIOD) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(CPU_PERIOD - 1);

  logic [7:0]       lfsr_q;
  logic [PER_W-1:0] per_q;

  // The LFSR and period counter free-run; new_game does not reseed them.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      lfsr_q <= LFSR_SEED;
      per_q  <= '0;
    end else begin
      lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
      per_q  <= (per_q == PER_LAST) ? '0 : per_q + 1'b1;
    end
  end

  assign rp = (per_q == PER_LAST) && (lfsr_q[3:0] < cpu_level);
`else
  edge_pulse u_right (
    .clk   (clk),
    .Reset (Reset),
    .level (R),
    .pulse (rp)
  );
`endif

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= PLAY;
      winner_q  <= WIN_NONE;
      pos_q     <= POS_CENTER;
      score_l_q <= '0;
      score_r_q <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      pos_q     <= pos_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    pos_d     = pos_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    hold_d    = hold_q;

    if (new_game) begin
      state_d   = PLAY;
      winner_d  = WIN_NONE;
      pos_d     = POS_CENTER;
      score_l_d = '0;
      score_r_d = '0;
      hold_d    = '0;
    end else begin
      case (state_q)
        PLAY: begin
          // Simultaneous pulls cancel; a pull off either end wins the round.
          if (lp && !rp) begin
            if (pos_q == POS_TOP) begin
              state_d  = WIN;
              winner_d = WIN_LEFT;
              if (score_l_q != SCORE_MAX) score_l_d = score_l_q + 1'b1;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end else if (rp && !lp) begin
            if (pos_q == '0) begin
              state_d  = WIN;
              winner_d = WIN_RIGHT;
              if (score_r_q != SCORE_MAX) score_r_d = score_r_q + 1'b1;
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
        end
        WIN: begin
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            if (((winner_q == WIN_LEFT) ? score_l_q : score_r_q) == SCORE_WIN) begin
              state_d = GAME_OVER;
            end else begin
              state_d  = PLAY;
              pos_d    = POS_CENTER;
              winner_d = WIN_NONE;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        GAME_OVER: begin
        end
        default: state_d = PLAY;
      endcase
    end
  end

  always_comb begin
    lights = '0;
    if (state_q == PLAY) lights = NUM_LIGHTS'(1) << pos_q;
  end

  assign winner    = winner_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = (state_q == GAME_OVER);

endmodule

// File: doc/tug_referee.md
Name: tug_referee

Overview:
- Game controller for the tug-of-war light chain.
- Turns the raw left/right player keys into single-cycle pull events and cancels simultaneous pulls.
- Moves a single lit position along NUM_LIGHTS lamps, detects a win at either end, keeps per-player round scores and sequences win display, next round and game over.
- Sits between the synchronized key inputs and the LED driver; replaces per-lamp next-state logic with one centralized position register.

Parameters:
- NUM_LIGHTS, 9, lamps in the chain (odd, 3..15); CENTER = (NUM_LIGHTS-1)/2.
- SCORE_W, 3, width of each score counter.
- WIN_SCORE, 3, round wins needed to end the game (1..2^SCORE_W-1).
- HOLD_CYCLES, 4, cycles the win display is held before the next round (>=1).
- CPU_PERIOD, 8, cycles between CPU pull attempts (only used with TUG_CPU_EN).

Ports:
- clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- L  in  1  left key, already synchronized, level.
- R  in  1  right key, already synchronized, level; ignored under TUG_CPU_EN.
- new_game  in  1  synchronous restart request.
- lights  out  NUM_LIGHTS  one-hot lamp vector; bit NUM_LIGHTS-1 is leftmost.
- winner  out  2  00 none, 10 left, 01 right.
- score_l  out  SCORE_W  left round wins.
- score_r  out  SCORE_W  right round wins.
- game_over  out  1  high while in GAME_OVER.
- cpu_level  in  4  CPU aggressiveness; port exists only under TUG_CPU_EN.

Behaviour:
- Clock and reset: single clock clk; Reset is asynchronous and active-high.
- Reset values: state=PLAY, pos=CENTER, lights=one-hot at CENTER, winner=00, scores=0, game_over=0, key history regs=0, hold counter=0.
- Pull detect:
  - lp = L & ~L_q and rp = R & ~R_q, where L_q and R_q are registered every cycle in all states.
  - A held key produces exactly one pull.
- Latency: a key first sampled high at edge k updates pos/lights at edge k (registered output, visible in the cycle after k).
- Priority: Reset > new_game > state logic.
- new_game, in any state: scores=0, winner=00, pos=CENTER, hold counter=0, state=PLAY.
- States:
  - PLAY:
    - lp&~rp: if pos==NUM_LIGHTS-1, go to WIN with winner=10, score_l+=1 (saturating), lights=0; else pos+=1.
    - rp&~lp: if pos==0, go to WIN with winner=01, score_r+=1; else pos-=1.
    - lp&rp, or no pull: hold.
  - WIN:
    - lights=0, winner held, pulls ignored; the hold counter counts HOLD_CYCLES cycles.
    - On expiry: if the winner's score==WIN_SCORE, go to GAME_OVER; else go to PLAY with pos=CENTER, winner=00.
  - GAME_OVER: lights=0, winner held, game_over=1, pulls ignored; leave only by Reset or new_game.
- Lights are always derived from pos in PLAY: exactly one bit set.
- Scores saturate at 2^SCORE_W-1 and never wrap.
- Reset mid-round or mid-WIN: immediate return to reset values; no partial score update.

Optional Feature:
- TUG_CPU_EN defined:
  - The right player is the CPU and R is ignored.
  - Internal 8-bit LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on Reset, steps every cycle.
  - A period counter wraps every CPU_PERIOD cycles. On wrap, rp=1 if lfsr[3:0] < cpu_level, else 0.
  - The cpu_level port is present.
- Undefined: rp comes from R edge detection; no LFSR, no period counter, no cpu_level port.

Decomposition:
- Package tug_pkg: state enum (PLAY, WIN, GAME_OVER), winner encodings (WIN_NONE, WIN_LEFT, WIN_RIGHT), LFSR seed and tap constant.
- Sub-module edge_pulse (clk, Reset, level in, pulse out), instantiated once per key. Everything else stays in tug_referee.

Test Plan:
- Assert Reset for 3 cycles while in PLAY at pos 6 -> lights=9'b000010000, scores 0/0, winner=00, asynchronously before the next edge.
- L held high for 10 cycles from center -> lights=9'b000100000 after one edge, then unchanged.
- 5 separate L pulses from center -> pos 5,6,7,8, then WIN: lights=0, winner=10, score_l=1. Exactly 4 cycles later -> PLAY, lights=9'b000010000, winner=00.
- L and R rising on the same edge -> no movement. R pulse then L pulse -> back to center.
- Left wins 3 rounds -> game_over=1, score_l=3; further pulses change nothing. new_game -> PLAY, scores 0/0, lights at center.
- TUG_CPU_EN, cpu_level=0 for 200 cycles -> never moves right. cpu_level=15 with L idle -> the CPU wins a round within 100 cycles, score_r=1.
